// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1rw1r_param
//  Purpose  : Parametrised single-clock memory with one read/write port
//             (port 0, lane-masked writes) and one read-only port (port 1).
//             Registered read results with valid strobes, optional extra
//             output register stage, and defined same-address
//             write/read collision behaviour with optional forwarding.
//  Revision : 1.0  initial release
// ============================================================================
module sram_1rw1r_param #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 8,
  parameter  int MASK_GRAN      = 8,
  parameter  int OUT_REG        = 0,
  parameter  int COLLISION_MODE = 0,
  localparam int NUM_WMASKS     = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port 0: read/write
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  // port 1: read only
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  // A word must split into whole mask lanes; anything else is a configuration bug.
  if ((MASK_GRAN <= 0) || ((DATA_WIDTH % MASK_GRAN) != 0)) begin : g_bad_mask_gran
    $error("sram_1rw1r_param: DATA_WIDTH must be a non-zero multiple of MASK_GRAN");
  end

  // --------------------------------------------------------------------------
  // Storage and request decode
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd1_word;

  assign w_wr0 = ~csb0 & ~web0;
  assign w_rd0 = ~csb0 &  web0;
  assign w_rd1 = ~csb1;

  // Expand the per-lane write enables into a per-bit mask.
  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign w_bitmask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask0[i]}};
  end

  // Merged word is both the value committed by a write and the value
  // forwarded to port 1 on a collision; an all-zero mask yields the old word.
  assign w_old0   = r_mem[addr0];
  assign w_merged = (w_old0 & ~w_bitmask) | (din0 & w_bitmask);

  // A same-address port 1 read during a port 0 write, regardless of mask.
  assign w_coll = w_wr0 & w_rd1 & (addr0 == addr1);

  if (COLLISION_MODE != 0) begin : g_fwd
    assign w_rd1_word = w_coll ? w_merged : r_mem[addr1];
  end else begin : g_no_fwd
    assign w_rd1_word = r_mem[addr1];
  end

  // Array update: contents are never cleared, and no write lands while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // storage is intentionally left untouched during reset
    end else if (w_wr0) begin
      r_mem[addr0] <= w_merged;
    end
  end

  // --------------------------------------------------------------------------
  // First read stage: capture read data and strobes at the sampling edge
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_dout0_s1;
  logic                  r_valid0_s1;
  logic [DATA_WIDTH-1:0] r_dout1_s1;
  logic                  r_valid1_s1;
  logic                  r_coll_s1;

  // Read result registers; data only updates on a read so it holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout0_s1  <= '0;
      r_valid0_s1 <= 1'b0;
      r_dout1_s1  <= '0;
      r_valid1_s1 <= 1'b0;
      r_coll_s1   <= 1'b0;
    end else begin
      r_valid0_s1 <= w_rd0;
      r_valid1_s1 <= w_rd1;
      r_coll_s1   <= w_coll;
      if (w_rd0) begin
        r_dout0_s1 <= w_old0;
      end
      if (w_rd1) begin
        r_dout1_s1 <= w_rd1_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional output register stage
  // --------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_dout0_s2;
    logic                  r_valid0_s2;
    logic [DATA_WIDTH-1:0] r_dout1_s2;
    logic                  r_valid1_s2;
    logic                  r_coll_s2;

    // Second stage: strobes shift every cycle, data only follows a valid result.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dout0_s2  <= '0;
        r_valid0_s2 <= 1'b0;
        r_dout1_s2  <= '0;
        r_valid1_s2 <= 1'b0;
        r_coll_s2   <= 1'b0;
      end else begin
        r_valid0_s2 <= r_valid0_s1;
        r_valid1_s2 <= r_valid1_s1;
        r_coll_s2   <= r_coll_s1;
        if (r_valid0_s1) begin
          r_dout0_s2 <= r_dout0_s1;
        end
        if (r_valid1_s1) begin
          r_dout1_s2 <= r_dout1_s1;
        end
      end
    end

    assign dout0       = r_dout0_s2;
    assign dout0_valid = r_valid0_s2;
    assign dout1       = r_dout1_s2;
    assign dout1_valid = r_valid1_s2;
    assign collision   = r_coll_s2;
  end else begin : g_no_out_reg
    assign dout0       = r_dout0_s1;
    assign dout0_valid = r_valid0_s1;
    assign dout1       = r_dout1_s1;
    assign dout1_valid = r_valid1_s1;
    assign collision   = r_coll_s1;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_1rw1r_param
//  Purpose  : Scoreboard bench for sram_1rw1r_param. Two instances: A uses
//             the default configuration (32x256, byte lanes, no output
//             register, old-data collisions); B is 64x16 with 16-bit lanes,
//             output register and forwarding collisions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_1rw1r_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  // instance A signals
  logic        a_csb0, a_web0, a_csb1;
  logic [3:0]  a_wmask0;
  logic [7:0]  a_addr0, a_addr1;
  logic [31:0] a_din0, a_dout0, a_dout1;
  logic        a_v0, a_v1, a_coll;

  // instance B signals
  logic        b_csb0, b_web0, b_csb1;
  logic [3:0]  b_wmask0;
  logic [3:0]  b_addr0, b_addr1;
  logic [63:0] b_din0, b_dout0, b_dout1;
  logic        b_v0, b_v1, b_coll;

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .MASK_GRAN(8), .OUT_REG(0), .COLLISION_MODE(0)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
    .dout0(a_dout0), .dout0_valid(a_v0),
    .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .dout1_valid(a_v1),
    .collision(a_coll)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .MASK_GRAN(16), .OUT_REG(1), .COLLISION_MODE(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
    .dout0(b_dout0), .dout0_valid(b_v0),
    .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .dout1_valid(b_v1),
    .collision(b_coll)
  );

  typedef struct {
    logic [63:0] data;
    logic        coll;
    int          cyc;
  } exp_t;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];

  int cyc = 0;
  int total = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checks
  task automatic check_resp(input string nm, input exp_t e, input logic [63:0] d,
                            input logic c, input bit use_c);
    total++;
    if (d === e.data && cyc == e.cyc && (!use_c || c === e.coll)) passed++;
    else $display("FAIL %s: got data=%h coll=%b cycle=%0d, required data=%h coll=%b cycle=%0d",
                  nm, d, c, cyc, e.data, e.coll, e.cyc);
  endtask

  task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  task automatic flag(input string nm);
    total++;
    $display("FAIL %s at cycle %0d: got a pulse, required none", nm, cyc);
  endtask

  // Monitor: pop and compare whenever a DUT port presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (a_v0) begin
      if (qa0.size() == 0) flag("A port0 unexpected valid");
      else begin e = qa0.pop_front(); check_resp("A port0", e, {32'h0, a_dout0}, 1'b0, 1'b0); end
    end
    if (a_v1) begin
      if (qa1.size() == 0) flag("A port1 unexpected valid");
      else begin e = qa1.pop_front(); check_resp("A port1", e, {32'h0, a_dout1}, a_coll, 1'b1); end
    end
    if (b_v0) begin
      if (qb0.size() == 0) flag("B port0 unexpected valid");
      else begin e = qb0.pop_front(); check_resp("B port0", e, b_dout0, 1'b0, 1'b0); end
    end
    if (b_v1) begin
      if (qb1.size() == 0) flag("B port1 unexpected valid");
      else begin e = qb1.pop_front(); check_resp("B port1", e, b_dout1, b_coll, 1'b1); end
    end
    if (a_coll && !a_v1) flag("A collision without valid");
    if (b_coll && !b_v1) flag("B collision without valid");
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle();
    a_csb0 = 1'b1; a_web0 = 1'b1; a_csb1 = 1'b1;
    b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic a_wr(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
    a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = ad; a_din0 = d; a_wmask0 = m;
  endtask

  task automatic a_rd0(input logic [7:0] ad, input logic [31:0] ex);
    exp_t e;
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = ad;
    e.data = {32'h0, ex}; e.coll = 1'b0; e.cyc = cyc + 1;
    qa0.push_back(e);
  endtask

  task automatic a_rd1(input logic [7:0] ad, input logic [31:0] ex, input logic c);
    exp_t e;
    a_csb1 = 1'b0; a_addr1 = ad;
    e.data = {32'h0, ex}; e.coll = c; e.cyc = cyc + 1;
    qa1.push_back(e);
  endtask

  task automatic b_wr(input logic [3:0] ad, input logic [63:0] d, input logic [3:0] m);
    b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = ad; b_din0 = d; b_wmask0 = m;
  endtask

  task automatic b_rd0(input logic [3:0] ad, input logic [63:0] ex);
    exp_t e;
    b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = ad;
    e.data = ex; e.coll = 1'b0; e.cyc = cyc + 2;
    qb0.push_back(e);
  endtask

  task automatic b_rd1(input logic [3:0] ad, input logic [63:0] ex, input logic c);
    exp_t e;
    b_csb1 = 1'b0; b_addr1 = ad;
    e.data = ex; e.coll = c; e.cyc = cyc + 2;
    qb1.push_back(e);
  endtask

  task automatic check_outputs_zero(input string when);
    check_val({when, " A dout0"}, {32'h0, a_dout0}, 64'h0);
    check_val({when, " A dout1"}, {32'h0, a_dout1}, 64'h0);
    check_val({when, " A strobes"}, {61'h0, a_v0, a_v1, a_coll}, 64'h0);
    check_val({when, " B dout0"}, b_dout0, 64'h0);
    check_val({when, " B dout1"}, b_dout1, 64'h0);
    check_val({when, " B strobes"}, {61'h0, b_v0, b_v1, b_coll}, 64'h0);
  endtask

  function automatic logic [63:0] bword(input int i);
    return 64'h0102_0304_0506_0700 | 64'(i);
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    idle();
    a_wmask0 = '0; a_addr0 = '0; a_addr1 = '0; a_din0 = '0;
    b_wmask0 = '0; b_addr0 = '0; b_addr1 = '0; b_din0 = '0;

    // Reset held with random request traffic: outputs must stay cleared.
    reset_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      a_csb0 = 1'($urandom); a_web0 = 1'($urandom); a_csb1 = 1'($urandom);
      a_wmask0 = 4'($urandom); a_addr0 = 8'($urandom); a_addr1 = 8'($urandom);
      a_din0 = $urandom;
      b_csb0 = 1'($urandom); b_web0 = 1'($urandom); b_csb1 = 1'($urandom);
      b_wmask0 = 4'($urandom); b_addr0 = 4'($urandom); b_addr1 = 4'($urandom);
      b_din0 = {$urandom, $urandom};
    end
    @(negedge clk);
    check_outputs_zero("reset");

    // Release; first requests are taken at the very next edge.
    idle();
    reset_n = 1'b1;
    a_wr(8'h10, 32'hAABB_CCDD, 4'hF);
    b_wr(4'h8, 64'h0011_2233_4455_6677, 4'hF);
    b_rd1(4'h8, 64'h0011_2233_4455_6677, 1'b1);
    step();

    // ---- instance A directed sequence
    a_wr(8'h10, 32'h1122_3344, 4'b0101);                               step();
    a_rd0(8'h10, 32'hAA22_CC44); a_rd1(8'h10, 32'hAA22_CC44, 1'b0);    step();
    a_wr(8'h20, 32'h0000_0000, 4'hF);                                  step();
    a_wr(8'h20, 32'hFFFF_FFFF, 4'b0011); a_rd1(8'h20, 32'h0, 1'b1);    step();
    a_rd0(8'h20, 32'h0000_FFFF); a_rd1(8'h20, 32'h0000_FFFF, 1'b0);    step();
    a_wr(8'hFF, 32'hDEAD_BEEF, 4'hF);                                  step();
    a_wr(8'h00, 32'h0123_4567, 4'hF); a_rd1(8'hFF, 32'hDEAD_BEEF, 1'b0); step();
    a_rd0(8'hFF, 32'hDEAD_BEEF); a_rd1(8'h00, 32'h0123_4567, 1'b0);    step();
    a_wr(8'hFF, 32'h0000_0000, 4'h0); a_rd1(8'hFF, 32'hDEAD_BEEF, 1'b1); step();
    a_rd0(8'hFF, 32'hDEAD_BEEF);                                       step();
    a_wr(8'h30, 32'hCAFE_F00D, 4'hF);                                  step();
    a_rd0(8'h30, 32'hCAFE_F00D); a_rd1(8'h30, 32'hCAFE_F00D, 1'b0);    step();

    // ---- instance B directed sequence
    for (int i = 0; i < 8; i++) begin
      b_wr(4'(i), bword(i), 4'hF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      b_rd1(4'(i), bword(i), 1'b0);
      step();
    end
    b_wr(4'hF, 64'h0, 4'hF);                                           step();
    b_wr(4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011);
    b_rd1(4'hF, 64'h0000_0000_FFFF_FFFF, 1'b1);                        step();
    b_rd0(4'hF, 64'h0000_0000_FFFF_FFFF);                              step();
    b_rd0(4'h0, bword(0));                                             step();
    b_wr(4'h3, 64'hAAAA_BBBB_CCCC_DDDD, 4'b1010);                      step();
    b_rd0(4'h3, 64'hAAAA_0304_CCCC_0703);                              step();
    repeat (4) step();

    // ---- reset while reads are in flight: no result may emerge
    b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'h3;
    step();
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'h10;
    #2 reset_n = 1'b0;
    step();
    step();
    check_outputs_zero("mid-reset");
    reset_n = 1'b1;
    repeat (3) step();

    // Words committed before the reset read back intact.
    a_rd0(8'h10, 32'hAA22_CC44);
    b_rd0(4'h3, 64'hAAAA_0304_CCCC_0703);
    b_rd1(4'hF, 64'h0000_0000_FFFF_FFFF, 1'b0);
    step();
    repeat (5) step();

    // Every expected response must have been consumed.
    check_val("drain A port0", 64'(qa0.size()), 64'h0);
    check_val("drain A port1", 64'(qa1.size()), 64'h0);
    check_val("drain B port0", 64'(qb0.size()), 64'h0);
    check_val("drain B port1", 64'(qb1.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
